cache_line_fill_responder: RTL
==============================

Name: cache_line_fill_responder

Overview:
- Memory-side responder for the instruction-cache miss path.
- On a line-fill request from the cache controller, it fetches a whole cache line from main memory one word at a time.
- It assembles the words into a line buffer, then hands the line back with a one-cycle done pulse so the cache can write the line and release the PC stall.
- Sits between the cache controller and the main-memory read port.

Parameters:
- WORDS_PER_LINE, 8, 32-bit words per cache line; power of two, 2..16.
- ADDR_W, 32, byte-address width.
- DATA_W, 32, memory word width; fixed at 32.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- fill_req  in  1  cache requests a line fill; sampled only in IDLE.
- fill_addr  in  ADDR_W  any byte address inside the missed line.
- fill_busy  out  1  high while a fill is in progress.
- fill_done  out  1  one-cycle pulse; line_data is valid in this cycle.
- line_data  out  WORDS_PER_LINE*DATA_W  assembled line; word i at bits [32i+31:32i].
- mem_rd  out  1  one-cycle read strobe to main memory.
- mem_addr  out  ADDR_W  word-aligned read address.
- mem_rdata  in  DATA_W  read data from memory.
- mem_rvalid  in  1  mem_rdata is valid this cycle; arrives one or more cycles after mem_rd.

Behaviour:
- Reset (RST=1 at a clock edge, any state, including mid-fill):
  - state -> IDLE; word index -> 0.
  - fill_busy, fill_done, mem_rd = 0; mem_addr = 0; line_data = all zeros.
  - Any in-flight memory response after reset is ignored.
- Line base: base = fill_addr with the low log2(WORDS_PER_LINE*4) bits forced to 0, latched in IDLE when fill_req=1.
- States (registered; outputs decoded from state):
  - IDLE:
    - fill_busy=0, mem_rd=0.
    - fill_req=1 -> latch base, index=0, go to ISSUE.
    - Otherwise stay in IDLE.
  - ISSUE:
    - fill_busy=1, mem_rd=1, mem_addr = base + 4*index.
    - Always -> WAIT next cycle.
  - WAIT:
    - fill_busy=1, mem_rd=0, mem_addr holds its value.
    - mem_rvalid=1 -> write mem_rdata into line word[index].
      - If index == WORDS_PER_LINE-1 -> DONE.
      - Else index+1, -> ISSUE.
    - mem_rvalid=0 -> stay in WAIT with no timeout.
  - DONE:
    - fill_done=1, fill_busy=1.
    - Always -> IDLE next cycle.
- line_data:
  - Holds its contents after DONE until overwritten word-by-word by the next fill.
  - It is not cleared at the start of a fill.
- Ignored inputs:
  - fill_req asserted outside IDLE is ignored, not queued.
  - fill_req held high through DONE starts a new fill only after returning to IDLE.
  - mem_rvalid outside WAIT is ignored; the line buffer is unchanged.
- Index width: log2(WORDS_PER_LINE) bits. Only the transition to DONE occurs at the last index, so the index never wraps in use.
- Address arithmetic: base + 4*index is modulo 2^ADDR_W. A line at the top of the address space produces no carry beyond ADDR_W.
- Latency:
  - With mem_rvalid exactly one cycle after mem_rd, fill_done rises 2*WORDS_PER_LINE+1 cycles after the cycle fill_req is sampled (17 cycles for 8 words).
  - Each extra memory wait cycle adds one cycle.
- Single outstanding memory read at all times; mem_rd is never asserted in consecutive cycles.

Test Plan:
- Basic fill: fill_addr=0x0000_1234, one-cycle memory returning data = address -> mem_addr sequence 0x1220, 0x1224 … 0x123C; line word i = 0x1220+4i; fill_done pulse exactly 17 cycles after request; fill_busy high throughout.
- Variable memory latency: rvalid delayed 3 cycles on word 2, 0 extra otherwise -> fill_done at cycle 20; word 2 holds the delayed data; mem_rd pulses exactly 8 times, each one cycle wide.
- Request while busy: fill_req re-pulsed with fill_addr=0x4000 during word 4 -> ignored; the current line completes with base 0x1220; no 0x4000 reads are issued.
- Back-to-back: fill_req held high continuously -> after fill_done, one IDLE cycle, then a second fill starts; line_data holds the first line until the second fill's word 0 returns.
- Reset mid-fill: RST=1 in WAIT at word 5 -> next cycle all outputs 0 and line_data zero; a subsequent stray mem_rvalid does not alter line_data; a new fill then completes normally.
- Address-space top: fill_addr=0xFFFF_FFF0 -> mem_addr runs 0xFFFF_FFE0 … 0xFFFF_FFFC with no overflow; fill_done asserts normally.

Source files
------------

// File: rtl/cache_line_fill_responder.sv
// Instruction-cache line-fill responder.
// Fetches one cache line from main memory a word at a time, keeping a single
// read outstanding, and assembles the words into a line buffer. A one-cycle
// fill_done pulse marks the cycle in which line_data holds the complete line.
module cache_line_fill_responder #(
    parameter int WORDS_PER_LINE = 8,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic                             fill_req,
    input  logic [ADDR_W-1:0]                fill_addr,
    output logic                             fill_busy,
    output logic                             fill_done,
    output logic [WORDS_PER_LINE*DATA_W-1:0] line_data,
    output logic                             mem_rd,
    output logic [ADDR_W-1:0]                mem_addr,
    input  logic [DATA_W-1:0]                mem_rdata,
    input  logic                             mem_rvalid
);

    localparam int IDX_W = $clog2(WORDS_PER_LINE);

    // Byte offset inside a line; cleared to form the line base.
    localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(WORDS_PER_LINE * 4 - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx;
    logic             rd_ret;
    logic             last_word;

    // A response only counts while a read is outstanding.
    assign rd_ret    = (state == WAIT) && mem_rvalid;
    assign last_word = (idx == LAST_IDX);

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic and state-decoded strobes.
    always_comb begin
        state_nxt = state;
        fill_busy = 1'b1;
        fill_done = 1'b0;
        mem_rd    = 1'b0;
        case (state)
            IDLE: begin
                fill_busy = 1'b0;
                if (fill_req) state_nxt = ISSUE;
            end
            ISSUE: begin
                mem_rd    = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (mem_rvalid) state_nxt = last_word ? DONE : ISSUE;
            end
            DONE: begin
                fill_done = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Word index and read address: base latched on accept, stepped by one
    // word per returned response. The add wraps naturally at the top of the
    // address space; the last word goes to DONE, so idx never wraps.
    always_ff @(posedge CLK) begin
        if (RST) begin
            idx      <= '0;
            mem_addr <= '0;
        end else if (state == IDLE && fill_req) begin
            idx      <= '0;
            mem_addr <= fill_addr & ~LINE_MASK;
        end else if (rd_ret && !last_word) begin
            idx      <= idx + 1'b1;
            mem_addr <= mem_addr + ADDR_W'(4);
        end
    end

    // Line buffer, one register per word. Words are only overwritten as the
    // next fill returns them, so the previous line stays readable meanwhile.
    for (genvar g = 0; g < WORDS_PER_LINE; g++) begin : g_word
        logic [DATA_W-1:0] word_q;

        // Capture the returning word into its slot.
        always_ff @(posedge CLK) begin
            if (RST)                                word_q <= '0;
            else if (rd_ret && idx == IDX_W'(g))    word_q <= mem_rdata;
        end

        assign line_data[g*DATA_W +: DATA_W] = word_q;
    end

endmodule
